useq_sequencer: RTL and testbench

- Parametrised micro-sequencer; the next generation of the 5-bit load/increment micro-PC.
- Adds conditional branch, call/return with a hardware return stack, hold, soft restart, a global enable and sticky error reporting.
- Sits between the microcode ROM (drives op/target/cond from the current microword) and the ROM address input (upc).

---
 rtl/useq_pkg.sv | 17 +
 rtl/useq_stack.sv | 63 ++++++
 rtl/useq_sequencer.sv | 136 +++++++++++++
 tb/tb_useq_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared types for the micro-sequencer: opcode encoding and default address width.
package useq_pkg;

  localparam int unsigned UseqAwDefault = 5;

  typedef enum logic [2:0] {
    OpNext = 3'b000,
    OpJmp  = 3'b001,
    OpJcc  = 3'b010,
    OpCall = 3'b011,
    OpRet  = 3'b100,
    OpHold = 3'b101,
    OpRst  = 3'b110,
    OpRsvd = 3'b111
  } useq_op_e;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the micro-sequencer; push and pop are never issued together.
module useq_stack #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push && !full) begin
      count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry i holds the return address pushed when occupancy was i; contents need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push && !full && count_q == CW'(i)) begin
        mem_q[i] <= push_data;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (count_q == CW'(i + 1)) begin
        top = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/useq_sequencer.sv
// Micro-sequencer: registered upc with jump/branch/call/return and sticky error.
// Optional breakpoint/halt support is compiled in with USEQ_BRKPT_EN.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int unsigned    AW         = UseqAwDefault,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [AW-1:0]  RESET_ADDR = '0,
  localparam int unsigned   SW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  useq_op_e      op,
  input  logic          cond,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] upc,
  output logic [SW-1:0] sp,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          err
`ifdef USEQ_BRKPT_EN
  ,
  input  logic [AW-1:0] brk_addr,
  input  logic          brk_arm,
  input  logic          resume,
  output logic          halted
`endif
);

  logic [AW-1:0] upc_q, upc_d, upc_inc, stack_top;
  logic          err_q, err_d;
  logic          push, pop, clear;
  logic          blocked;

  assign upc_inc = upc_q + AW'(1);
  assign upc     = upc_q;
  assign err     = err_q;

  useq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_data (upc_inc),
    .top       (stack_top),
    .count     (sp),
    .full      (stack_full),
    .empty     (stack_empty)
  );

`ifdef USEQ_BRKPT_EN
  logic halted_q, halted_d;

  // While halted only RST, or any op paired with resume, gets through.
  assign blocked = halted_q && !resume && (op != OpRst);
  assign halted  = halted_q;

  always_comb begin
    halted_d = halted_q;
    if (en) begin
      if (op == OpRst) begin
        halted_d = 1'b0;
      end else begin
        halted_d = (halted_q && !resume) || (brk_arm && (upc_d == brk_addr));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    upc_d = upc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
    if (en && !blocked) begin
      unique case (op)
        OpNext: upc_d = upc_inc;
        OpJmp:  upc_d = target;
        OpJcc:  upc_d = cond ? target : upc_inc;
        OpCall: begin
          if (stack_full) begin
            upc_d = upc_inc;
            err_d = 1'b1;
          end else begin
            push  = 1'b1;
            upc_d = target;
          end
        end
        OpRet: begin
          if (stack_empty) begin
            upc_d = upc_inc;
            err_d = 1'b1;
          end else begin
            pop   = 1'b1;
            upc_d = stack_top;
          end
        end
        OpHold: ;
        OpRst: begin
          upc_d = RESET_ADDR;
          err_d = 1'b0;
          clear = 1'b1;
        end
        OpRsvd: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q <= RESET_ADDR;
      err_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Table-driven scoreboard bench for useq_sequencer (AW=5, DEPTH=4, RESET_ADDR=0).
module tb_useq_sequencer;
  import useq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  useq_op_e   op;
  logic       cond;
  logic [4:0] target;
  logic [4:0] upc;
  logic [2:0] sp;
  logic       stack_full, stack_empty, err;
`ifdef USEQ_BRKPT_EN
  logic [4:0] brk_addr;
  logic       brk_arm, resume, halted;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       en;
    useq_op_e   op;
    logic       cond;
    logic [4:0] target;
    logic [4:0] upc;
    logic [2:0] sp;
    logic       err;
  } vec_t;

  typedef struct {
    string      tag;
    logic [4:0] upc;
    logic [2:0] sp;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  useq_sequencer #(
    .AW         (5),
    .DEPTH      (4),
    .RESET_ADDR (5'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .cond        (cond),
    .target      (target),
    .upc         (upc),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err)
`ifdef USEQ_BRKPT_EN
    ,
    .brk_addr    (brk_addr),
    .brk_arm     (brk_arm),
    .resume      (resume),
    .halted      (halted)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".upc"}, 32'(upc), 32'(e.upc));
      chk({e.tag, ".sp"}, 32'(sp), 32'(e.sp));
      chk({e.tag, ".err"}, 32'(err), 32'(e.err));
      chk({e.tag, ".full_empty"}, 32'({stack_full, stack_empty}),
          32'({e.sp == 3'd4, e.sp == 3'd0}));
    end
  endtask

  task automatic step(input string tag, input logic e_i, input useq_op_e o, input logic c,
                      input logic [4:0] t, input logic [4:0] eu, input logic [2:0] es,
                      input logic ee);
    exp_t x;
    @(negedge clk);
    en = e_i; op = o; cond = c; target = t;
    x.tag = tag; x.upc = eu; x.sp = es; x.err = ee;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = OpHold; cond = 1'b0; target = '0;
`ifdef USEQ_BRKPT_EN
    brk_addr = '0; brk_arm = 1'b0; resume = 1'b0;
`endif
    //              en  op      c     tgt    upc    sp    err
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd1,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd2,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd3,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpJmp,  1'b0, 5'd31, 5'd31, 3'd0, 1'b0});
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd0,  3'd0, 1'b0}); // wrap
    vecs.push_back('{1'b1, OpJcc,  1'b0, 5'd10, 5'd1,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpJcc,  1'b1, 5'd10, 5'd10, 3'd0, 1'b0});
    vecs.push_back('{1'b1, OpJmp,  1'b0, 5'd3,  5'd3,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd8,  5'd8,  3'd1, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd20, 5'd20, 3'd2, 1'b0});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd9,  3'd1, 1'b0});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd4,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd31, 5'd31, 3'd1, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd0,  5'd0,  3'd2, 1'b0}); // pushes wrapped 0
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd0,  3'd1, 1'b0});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd5,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd1,  5'd1,  3'd1, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd2,  5'd2,  3'd2, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd3,  5'd3,  3'd3, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd4,  5'd4,  3'd4, 1'b0});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd9,  5'd5,  3'd4, 1'b1}); // overflow
    vecs.push_back('{1'b1, OpHold, 1'b0, 5'd0,  5'd5,  3'd4, 1'b1});
    vecs.push_back('{1'b0, OpJmp,  1'b0, 5'd17, 5'd5,  3'd4, 1'b1});
    vecs.push_back('{1'b0, OpJmp,  1'b0, 5'd17, 5'd5,  3'd4, 1'b1});
    vecs.push_back('{1'b0, OpRst,  1'b0, 5'd17, 5'd5,  3'd4, 1'b1});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd4,  3'd3, 1'b1});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd3,  3'd2, 1'b1});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd2,  3'd1, 1'b1});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd6,  3'd0, 1'b1});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd7,  3'd0, 1'b1}); // underflow
    vecs.push_back('{1'b1, OpRst,  1'b0, 5'd0,  5'd0,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpRet,  1'b0, 5'd0,  5'd1,  3'd0, 1'b1});
    vecs.push_back('{1'b1, OpRst,  1'b0, 5'd0,  5'd0,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd1,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpRsvd, 1'b0, 5'd0,  5'd1,  3'd0, 1'b1});
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd2,  3'd0, 1'b1});
    vecs.push_back('{1'b1, OpCall, 1'b0, 5'd12, 5'd12, 3'd1, 1'b1});
    vecs.push_back('{1'b1, OpRst,  1'b0, 5'd0,  5'd0,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd1,  3'd0, 1'b0});
    vecs.push_back('{1'b1, OpNext, 1'b0, 5'd0,  5'd2,  3'd0, 1'b0});

    #3;
    chk("reset.upc", 32'(upc), 32'd0);
    chk("reset.sp", 32'(sp), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].op, vecs[i].cond, vecs[i].target,
           vecs[i].upc, vecs[i].sp, vecs[i].err);
    end

    // Asynchronous reset mid-run: upc must drop before the next clock edge.
    @(negedge clk);
    op = OpNext; en = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_reset.upc", 32'(upc), 32'd0);
    chk("async_reset.sp", 32'(sp), 32'd0);
    @(negedge clk);
    chk("reset_held.upc", 32'(upc), 32'd0);
    reset = 1'b0;

`ifdef USEQ_BRKPT_EN
    brk_addr = 5'd5; brk_arm = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("brk_next%0d", i), 1'b1, OpNext, 1'b0, 5'd0, 5'(i), 3'd0, 1'b0);
      chk($sformatf("brk_next%0d.halted", i), 32'(halted), 32'(i == 5));
    end
    step("halt_next", 1'b1, OpNext, 1'b0, 5'd0, 5'd5, 3'd0, 1'b0);
    chk("halt_next.halted", 32'(halted), 32'd1);
    step("halt_jmp", 1'b1, OpJmp, 1'b0, 5'd17, 5'd5, 3'd0, 1'b0);
    chk("halt_jmp.halted", 32'(halted), 32'd1);
    resume = 1'b1;
    step("resume_next", 1'b1, OpNext, 1'b0, 5'd0, 5'd6, 3'd0, 1'b0);
    chk("resume_next.halted", 32'(halted), 32'd0);
    resume = 1'b0; brk_arm = 1'b0;
`endif

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
